mux_n_skid: RTL and testbench
=============================

Name: mux_n_skid

Overview:
Parametrised N:1 selection stage with a registered, back-pressurable output. It generalises the pipeline's 2:1 don't-care mux in three ways: any input count, a defined fallback for unknown or out-of-range selects, and a 2-entry skid buffer so the mux can sit between stall-capable pipeline stages (operand forwarding, writeback select). It also counts invalid selects for debug.

Parameters:
- WIDTH, 32, data width per input.
- N_IN, 4, number of data inputs (>= 2).
- DEFAULT_IDX, 0, input chosen when sel is X/Z or >= N_IN.
- ERR_W, 16, width of the saturating error counter.
- SEL_W (localparam), $clog2(N_IN), select width.

Ports:
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, N_IN*WIDTH, flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel, input, SEL_W, input index.
- in_valid, input, 1, upstream offers in_data/sel.
- in_ready, output, 1, block can accept this cycle.
- flush, input, 1, synchronous discard of all buffered entries.
- out_data, output, WIDTH, selected data, registered.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts out_data.
- sel_err, output, 1, one-cycle pulse: an accepted transfer used the fallback.
- err_count, output, ERR_W, saturating count of accepted invalid selects.

Behaviour:
- Reset (async assert, sync release): state EMPTY; out_valid=0; out_data=0; sel_err=0; err_count=0; in_ready=1.
- Select rule (combinational): index = sel if sel is known and < N_IN, else DEFAULT_IDX. The invalid flag is set in that fallback case. X/Z detection applies in simulation only; synthesis sees only the range check.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (state != FULL). It is decoded from registered state only, so there is no combinational path from out_ready to in_ready.
- Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 transfer per cycle with out_ready held high.
- State machine (main register M drives out_data; skid register S):
  - EMPTY + accept -> ONE; M <= selected data.
  - ONE + accept + pop -> ONE; M <= new data.
  - ONE + accept + !pop -> FULL; S <= new data.
  - ONE + !accept + pop -> EMPTY.
  - FULL + pop -> ONE; M <= S. No accept is possible in FULL.
  - Any other combination holds state.
- out_valid = (state != EMPTY).
- Ordering is strictly FIFO. Data in M is stable while out_valid & !out_ready.
- flush:
  - Next edge forces EMPTY; out_valid=0 the following cycle.
  - An accept in the flush cycle is discarded and does not update err_count or sel_err.
  - A pop in the flush cycle still completes downstream.
  - M/S contents are don't-care after flush.
- sel_err: registered; high for exactly the cycle after an accepted invalid select.
- err_count: increments on the same event; saturates at 2^ERR_W-1; cleared only by reset, not by flush.
- Reset asserted mid-operation drops all buffered entries immediately, with no output handshake.

Decomposition:
- Package mux_pkg:
  - skid_state_e enum {EMPTY, ONE, FULL}.
  - Function sel_is_valid(sel, n_in) implementing the range and X check.
- Sub-module mux_n_sel: purely combinational N:1 with DEFAULT_IDX fallback and invalid-flag output. mux_n_skid instantiates one copy; the skid FSM, sel_err and counter live in the parent.

Test Plan:
- Streaming (defaults): in_data inputs = 0xA0..0xA3, sel cycles 0,1,2,3, in_valid=1, out_ready=1 -> out_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting 1 cycle after first accept; in_ready constantly 1.
- Back-pressure: out_ready=0, push 0x11 then 0x22 -> state FULL, in_ready=0, out_data holds 0x11. Raise out_ready -> 0x11 then 0x22 appear, in_ready returns to 1 one cycle after the first pop, and no data is lost or duplicated.
- Invalid select (N_IN=3, DEFAULT_IDX=0): sel=2'b11 and sel=2'bx0 with input 0 = 0x5 -> out_data 0x5 both times, sel_err pulses twice, err_count=2.
- Saturation (ERR_W=2): 5 invalid accepts -> err_count stops at 3.
- Flush: FULL with 0x33/0x44, assert flush together with in_valid carrying sel=3 (invalid) -> next cycle out_valid=0, in_ready=1, err_count unchanged, and the following stream resumes correctly.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> out_valid, sel_err go 0 and in_ready goes 1 immediately, err_count=0; normal operation after release.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 select stage with skid output.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mux_pkg;

  // Occupancy of the two-entry output buffer (main register plus skid register).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // True when sel names a real input. In a 4-state simulator an X/Z select
  // makes the comparison X, so the if falls through and reports invalid.
  // In hardware only the range check remains.
  function automatic logic sel_is_valid(input logic [31:0] sel, input logic [31:0] n_in);
    logic ok;
    ok = 1'b0;
    if (sel < n_in) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N:1 data select with a fixed fallback input for bad selects.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent owns all flow control.
module mux_n_sel
  import mux_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int N_IN        = 4,
  parameter  int DEFAULT_IDX = 0,
  localparam int SEL_W       = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_invalid
);

  logic             w_valid;
  logic [SEL_W-1:0] w_idx;

  // Resolve the effective index, substituting the fallback for unknown or out-of-range selects.
  always_comb begin
    w_valid   = sel_is_valid(32'(i_sel), 32'(N_IN));
    w_idx     = w_valid ? i_sel : SEL_W'(DEFAULT_IDX);
    o_invalid = ~w_valid;
  end

  // Pick the data slice for the resolved index; w_idx is always in range here.
  always_comb begin
    o_data = i_data[DEFAULT_IDX*WIDTH +: WIDTH];
    for (int i = 0; i < N_IN; i++) begin
      if (w_idx == SEL_W'(i)) begin
        o_data = i_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_n_skid.sv
// N:1 select stage feeding a two-entry skid buffer, with invalid-select debug counter.
// Latency: 1 cycle from accept to out_valid; 1 transfer/cycle sustained.
// Backpressure: in_ready drops only when both entries are held; decoded from state, no comb path from out_ready.
module mux_n_skid
  import mux_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int N_IN        = 4,
  parameter  int DEFAULT_IDX = 0,
  parameter  int ERR_W       = 16,
  localparam int SEL_W       = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [ERR_W-1:0]      err_count
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;
  logic             r_sel_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_inv;
  logic             w_accept;
  logic             w_pop;
  logic             w_take;
  logic             w_ld_m_in;
  logic             w_ld_m_s;
  logic             w_ld_s;

  mux_n_sel #(
    .WIDTH      (WIDTH),
    .N_IN       (N_IN),
    .DEFAULT_IDX(DEFAULT_IDX)
  ) u_sel (
    .i_data   (in_data),
    .i_sel    (sel),
    .o_data   (w_sel_data),
    .o_invalid(w_sel_inv)
  );

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_m;
  assign sel_err   = r_sel_err;
  assign err_count = r_err_cnt;

  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // An accept that coincides with flush is thrown away, so it must not count.
  assign w_take    = w_accept & ~flush;

  // Next-state and register-load decode for the skid buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_m_in   = 1'b0;
    w_ld_m_s    = 1'b0;
    w_ld_s      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_ld_m_in   = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_ld_m_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_ld_s      = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_state_nxt = ONE;
          w_ld_m_s    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
    // Flush wins over everything; buffer contents become don't-care.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_ld_m_in   = 1'b0;
      w_ld_m_s    = 1'b0;
      w_ld_s      = 1'b0;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main (output-facing) and skid data registers; main holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= '0;
      r_s <= '0;
    end else begin
      if (w_ld_m_in) begin
        r_m <= w_sel_data;
      end else if (w_ld_m_s) begin
        r_m <= r_s;
      end
      if (w_ld_s) begin
        r_s <= w_sel_data;
      end
    end
  end

  // Invalid-select pulse and saturating counter; flush leaves the counter alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_sel_err <= w_take & w_sel_inv;
      if (w_take && w_sel_inv && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_n_skid.sv
// Bench for mux_n_skid: default 4-input instance and a 3-input instance with a 2-bit error counter.
// Inputs change on the falling edge; outputs are observed on the falling edge before the next rising edge.
// Expected output data is queued at accept time and popped when the DUT hands data downstream.
module tb_mux_n_skid;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Instance A: defaults (WIDTH=32, N_IN=4, DEFAULT_IDX=0, ERR_W=16)
  logic [127:0] a_in_data = '0;
  logic [1:0]   a_sel = '0;
  logic         a_in_valid = 1'b0;
  logic         a_in_ready;
  logic         a_flush = 1'b0;
  logic [31:0]  a_out_data;
  logic         a_out_valid;
  logic         a_out_ready = 1'b0;
  logic         a_sel_err;
  logic [15:0]  a_err_count;

  // Instance B: N_IN=3, DEFAULT_IDX=0, ERR_W=2
  logic [95:0]  b_in_data = '0;
  logic [1:0]   b_sel = '0;
  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic         b_flush = 1'b0;
  logic [31:0]  b_out_data;
  logic         b_out_valid;
  logic         b_out_ready = 1'b0;
  logic         b_sel_err;
  logic [1:0]   b_err_count;

  mux_n_skid dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sel_err(a_sel_err), .err_count(a_err_count)
  );

  mux_n_skid #(.WIDTH(32), .N_IN(3), .DEFAULT_IDX(0), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sel_err(b_sel_err), .err_count(b_err_count)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int          exp_err_b = 0;
  logic        b_sel_pend = 1'b0;
  logic        b_sel_prev = 1'b0;
  logic [31:0] exp_v;

  // Drive one cycle of A; queue the expected word when the accept will happen.
  task automatic drive_a(input logic v, input logic [1:0] s, input logic [127:0] d,
                         input logic rdy, input logic fl);
    @(negedge clk);
    a_in_valid  = v;
    a_sel       = s;
    a_in_data   = d;
    a_out_ready = rdy;
    a_flush     = fl;
    if (v && a_in_ready && !fl) exp_a.push_back(d[int'(s)*32 +: 32]);
  endtask

  // Drive one cycle of B; model the fallback select, the error pulse and the saturating count.
  task automatic drive_b(input logic v, input logic [1:0] s, input logic [95:0] d,
                         input logic rdy, input logic fl);
    logic       inv;
    logic [1:0] idx;
    @(negedge clk);
    b_sel_prev  = b_sel_pend;
    b_in_valid  = v;
    b_sel       = s;
    b_in_data   = d;
    b_out_ready = rdy;
    b_flush     = fl;
    inv = $isunknown(s) || (s >= 2'd3);
    idx = inv ? 2'd0 : s;
    b_sel_pend = v && b_in_ready && !fl && inv;
    if (v && b_in_ready && !fl) begin
      exp_b.push_back(d[int'(idx)*32 +: 32]);
      if (inv && exp_err_b < 3) exp_err_b++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", a_out_data); end
    checks++; if (a_sel_err !== 1'b0) begin failures++; $display("FAIL reset_sel_err got=%b exp=0", a_sel_err); end
    checks++; if (a_err_count !== 16'h0) begin failures++; $display("FAIL reset_err_count got=%h exp=0", a_err_count); end
    checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_b_flags got=%b%b exp=01", b_out_valid, b_in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [127:0] d;
    d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 7; i++) begin
      drive_a(i < 4, 2'(i % 4), d, 1'b1, 1'b0);
      checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, a_in_ready); end
      checks++; if (a_out_valid !== (i >= 1 && i <= 4)) begin failures++; $display("FAIL stream_out_valid cyc=%0d got=%b exp=%b", i, a_out_valid, (i >= 1 && i <= 4)); end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (exp_a.size() == 0) begin failures++; $display("FAIL stream_data got=%h exp=none", a_out_data); end
        else begin exp_v = exp_a.pop_front(); if (a_out_data !== exp_v) begin failures++; $display("FAIL stream_data got=%h exp=%h", a_out_data, exp_v); end end
      end
    end
    checks++; if (exp_a.size() != 0) begin failures++; $display("FAIL stream_drain left=%0d exp=0", exp_a.size()); end
  endtask

  task automatic test_back_pressure();
    drive_a(1'b1, 2'd0, {96'h0, 32'h11}, 1'b0, 1'b0);
    drive_a(1'b1, 2'd0, {96'h0, 32'h22}, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b0, 2'd0, '0, 1'b0, 1'b0);
      checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", a_in_ready); end
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h11) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/00000011", a_out_valid, a_out_data); end
    end
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b0, 2'd0, '0, 1'b1, 1'b0);
      if (i == 0) begin checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_first_pop_in_ready got=%b exp=0", a_in_ready); end end
      if (i == 1) begin checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_pop_in_ready got=%b exp=1", a_in_ready); end end
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (exp_a.size() == 0) begin failures++; $display("FAIL bp_data got=%h exp=none", a_out_data); end
        else begin exp_v = exp_a.pop_front(); if (a_out_data !== exp_v) begin failures++; $display("FAIL bp_data got=%h exp=%h", a_out_data, exp_v); end end
      end
    end
    checks++; if (exp_a.size() != 0 || a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain left=%0d vld=%b exp=0/0", exp_a.size(), a_out_valid); end
  endtask

  task automatic test_invalid_select();
    logic [95:0] d;
    logic [1:0]  sx;
    logic [1:0]  sels [5];
    logic        vs   [5];
    d  = {32'h5, 32'h77, 32'h5};
    sx = 2'bx0;
    sels = '{2'b11, sx, 2'd1, 2'd0, 2'd0};
    vs   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive_b(vs[i], sels[i], d, 1'b1, 1'b0);
      checks++; if (b_sel_err !== b_sel_prev) begin failures++; $display("FAIL inv_sel_err cyc=%0d got=%b exp=%b", i, b_sel_err, b_sel_prev); end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (exp_b.size() == 0) begin failures++; $display("FAIL inv_data got=%h exp=none", b_out_data); end
        else begin exp_v = exp_b.pop_front(); if (b_out_data !== exp_v) begin failures++; $display("FAIL inv_data got=%h exp=%h", b_out_data, exp_v); end end
      end
    end
    checks++; if (int'(b_err_count) != exp_err_b) begin failures++; $display("FAIL inv_err_count got=%0d exp=%0d", b_err_count, exp_err_b); end
  endtask

  task automatic test_flush();
    logic [95:0] d;
    d = {32'h9, 32'h8, 32'h7};
    drive_b(1'b1, 2'd0, {64'h0, 32'h33}, 1'b0, 1'b0);
    drive_b(1'b1, 2'd0, {64'h0, 32'h44}, 1'b0, 1'b0);
    drive_b(1'b0, 2'd0, d, 1'b0, 1'b0);
    checks++; if (b_in_ready !== 1'b0) begin failures++; $display("FAIL flush_full_in_ready got=%b exp=0", b_in_ready); end
    // Flush with an offered invalid select while full; the pop in this cycle still completes.
    drive_b(1'b1, 2'd3, d, 1'b1, 1'b1);
    if (b_out_valid && b_out_ready) begin
      checks++;
      exp_v = exp_b.pop_front();
      if (b_out_data !== exp_v) begin failures++; $display("FAIL flush_pop_data got=%h exp=%h", b_out_data, exp_v); end
    end
    exp_b.delete();
    drive_b(1'b0, 2'd0, d, 1'b0, 1'b0);
    checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b/%b exp=0/1", b_out_valid, b_in_ready); end
    checks++; if (int'(b_err_count) != exp_err_b || b_sel_err !== 1'b0) begin failures++; $display("FAIL flush_err got=%0d/%b exp=%0d/0", b_err_count, b_sel_err, exp_err_b); end
    // Flush while holding one entry, so the invalid select really is accepted and then discarded.
    drive_b(1'b1, 2'd1, d, 1'b0, 1'b0);
    drive_b(1'b1, 2'd3, d, 1'b0, 1'b1);
    exp_b.delete();
    drive_b(1'b0, 2'd0, d, 1'b0, 1'b0);
    checks++; if (b_out_valid !== 1'b0 || b_sel_err !== 1'b0 || int'(b_err_count) != exp_err_b) begin failures++; $display("FAIL flush_accept_discard got=%b/%b/%0d exp=0/0/%0d", b_out_valid, b_sel_err, b_err_count, exp_err_b); end
    // Resume streaming.
    for (int i = 0; i < 5; i++) begin
      drive_b(i < 3, 2'(i % 3), {32'hC2, 32'hC1, 32'hC0}, 1'b1, 1'b0);
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (exp_b.size() == 0) begin failures++; $display("FAIL flush_resume_data got=%h exp=none", b_out_data); end
        else begin exp_v = exp_b.pop_front(); if (b_out_data !== exp_v) begin failures++; $display("FAIL flush_resume_data got=%h exp=%h", b_out_data, exp_v); end end
      end
    end
    checks++; if (exp_b.size() != 0) begin failures++; $display("FAIL flush_resume_drain left=%0d exp=0", exp_b.size()); end
  endtask

  task automatic test_saturation();
    logic [95:0] d;
    d = {32'h3, 32'h2, 32'h1};
    for (int i = 0; i < 7; i++) begin
      drive_b(i < 5, 2'd3, d, 1'b1, 1'b0);
      checks++; if (b_sel_err !== b_sel_prev) begin failures++; $display("FAIL sat_sel_err cyc=%0d got=%b exp=%b", i, b_sel_err, b_sel_prev); end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (exp_b.size() == 0) begin failures++; $display("FAIL sat_data got=%h exp=none", b_out_data); end
        else begin exp_v = exp_b.pop_front(); if (b_out_data !== exp_v) begin failures++; $display("FAIL sat_data got=%h exp=%h", b_out_data, exp_v); end end
      end
    end
    checks++; if (int'(b_err_count) != exp_err_b) begin failures++; $display("FAIL sat_err_count got=%0d exp=%0d", b_err_count, exp_err_b); end
  endtask

  task automatic test_async_reset();
    drive_a(1'b1, 2'd0, {96'h0, 32'h11}, 1'b0, 1'b0);
    drive_a(1'b1, 2'd0, {96'h0, 32'h22}, 1'b0, 1'b0);
    drive_a(1'b0, 2'd0, '0, 1'b0, 1'b0);
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL areset_pre_full got=%b exp=0", a_in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL areset_flags got=%b/%b exp=0/1", a_out_valid, a_in_ready); end
    checks++; if (a_sel_err !== 1'b0 || b_sel_err !== 1'b0) begin failures++; $display("FAIL areset_sel_err got=%b/%b exp=0/0", a_sel_err, b_sel_err); end
    checks++; if (b_err_count !== 2'd0 || a_err_count !== 16'h0) begin failures++; $display("FAIL areset_err_count got=%0d/%0d exp=0/0", a_err_count, b_err_count); end
    exp_a.delete();
    exp_b.delete();
    exp_err_b  = 0;
    b_sel_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_a(i < 3, 2'(3 - i), {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1'b1, 1'b0);
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (exp_a.size() == 0) begin failures++; $display("FAIL areset_resume_data got=%h exp=none", a_out_data); end
        else begin exp_v = exp_a.pop_front(); if (a_out_data !== exp_v) begin failures++; $display("FAIL areset_resume_data got=%h exp=%h", a_out_data, exp_v); end end
      end
    end
    checks++; if (exp_a.size() != 0) begin failures++; $display("FAIL areset_resume_drain left=%0d exp=0", exp_a.size()); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_invalid_select();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
